// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate self-test sequencer: FSM state encoding,
// reference truth tables for common 2-input gates and the settle counter width.
// Truth-table bit index is {a,b}, so bit 0 is the a=0,b=0 response.
package gate_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } gate_seq_state_t;

  // Reference truth tables, bit index = {a,b}
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;

  // Width of the settle counter; covers SETTLE values 1..255
  localparam int SETTLE_W = 8;

  // Expected gate response for one input vector
  function automatic logic expected_bit(input logic [3:0] tt, input logic [1:0] vec);
    return tt[vec];
  endfunction

endpackage

// File: rtl/gate_seq_ctrl_settle_timer.sv
// Loadable down-counter that times how long each vector is held on the gate.
// Loading SETTLE-1 on entry to DRIVE makes zero assert in the SETTLE-th
// DRIVE cycle; the counter parks at zero until the next load.
module settle_timer
  import gate_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  // Load has priority; otherwise count down and stop at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - SETTLE_W'(1);
    end
  end

  // Terminal-count flag consumed by the sequencer FSM
  assign zero = (count == '0);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Self-test sequencer for a 2-input combinational gate. On start it drives
// {a,b} = 00, 01, 10, 11 onto the gate, holds each vector SETTLE cycles,
// samples the gate output for one cycle and compares it to EXPECT[{a,b}].
// At the end of the sweep it pulses done and reports err_count and pass.
//
// Optional feature: define GATE_SEQ_LOG_EN to add the observed[3:0] port,
// which captures the gate response for each vector.
//
// Handshake: start is a plain level request with no ready. It is sampled
// only while the FSM is in IDLE; in every other state it is ignored and
// nothing is queued. busy is high from the cycle after an accepted start
// through the last SAMPLE cycle, and done pulses for one cycle afterwards.
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter logic [3:0] EXPECT = OR_TT,
  parameter int         SETTLE = 4       // legal range 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef GATE_SEQ_LOG_EN
  ,
  output logic [3:0] observed
`endif
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  gate_seq_state_t state;
  logic [1:0]      vec;

  logic            accept;
  logic            last_vec;
  logic            mismatch;
  logic [2:0]      err_next;
  logic            timer_load;
  logic            settle_zero;

  // Decode of the current step: start acceptance, comparison and next count
  always_comb begin
    accept     = (state == IDLE) && start;
    last_vec   = (vec == 2'd3);
    mismatch   = (gate_c != expected_bit(EXPECT, vec));
    err_next   = err_count;
    if ((state == SAMPLE) && mismatch && (err_count < 3'd4)) begin
      err_next = err_count + 3'd1;
    end
    // The timer is reloaded on every edge that enters DRIVE
    timer_load = accept || ((state == SAMPLE) && !last_vec);
  end

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .zero     (settle_zero)
  );

  // Sequencer FSM with registered gate drive, status and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 2'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          gate_a <= 1'b0;
          gate_b <= 1'b0;
          done   <= 1'b0;
          if (accept) begin
            state     <= DRIVE;
            vec       <= 2'd0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= 3'd0;
          end
        end

        DRIVE: begin
          if (settle_zero) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          err_count <= err_next;
          if (last_vec) begin
            // Result reflects the vec 3 comparison made on this same edge
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_next == 3'd0);
            gate_a <= 1'b0;
            gate_b <= 1'b0;
          end else begin
            state           <= DRIVE;
            vec             <= vec + 2'd1;
            {gate_a, gate_b} <= vec + 2'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GATE_SEQ_LOG_EN
  // Capture log of the gate response, one bit per input vector
  always_ff @(posedge clk) begin
    if (rst) begin
      observed <= 4'd0;
    end else if (accept) begin
      observed <= 4'd0;
    end else if (state == SAMPLE) begin
      observed[vec] <= gate_c;
    end
  end
`endif

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Self-checking bench for gate_seq_ctrl. Two instances are built, one with
// SETTLE=4 and one with SETTLE=1, both expecting an OR gate. The gate under
// test is a behavioural truth table held in the bench, so any gate function
// can be attached. Expected timing and results come from a cycle-indexed
// model of the sweep: vector v is driven in cycles v*(S+1)+1 .. (v+1)*(S+1)
// and sampled at the end of cycle (v+1)*(S+1); done lands in cycle 4*(S+1)+1.
module tb_gate_seq_ctrl;
  import gate_seq_pkg::*;

  localparam logic [3:0] EXP0 = OR_TT;
  localparam int         S0   = 4;
  localparam logic [3:0] EXP1 = OR_TT;
  localparam int         S1   = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [3:0] tt;

  logic       start0, a0, b0, c0, busy0, done0, pass0;
  logic [2:0] err0;
  logic       start1, a1, b1, c1, busy1, done1, pass1;
  logic [2:0] err1;

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [2:0] m_err;
`ifdef GATE_SEQ_LOG_EN
  logic [3:0] obs0, obs1, m_obs;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- gate model and DUTs ----------------
  assign c0     = tt[{a0, b0}];
  assign c1     = tt[{a1, b1}];
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  gate_seq_ctrl #(.EXPECT(EXP0), .SETTLE(S0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start0),
    .gate_a    (a0),
    .gate_b    (b0),
    .gate_c    (c0),
    .busy      (busy0),
    .done      (done0),
    .pass      (pass0),
    .err_count (err0)
`ifdef GATE_SEQ_LOG_EN
    ,
    .observed  (obs0)
`endif
  );

  gate_seq_ctrl #(.EXPECT(EXP1), .SETTLE(S1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .gate_a    (a1),
    .gate_b    (b1),
    .gate_c    (c1),
    .busy      (busy1),
    .done      (done1),
    .pass      (pass1),
    .err_count (err1)
`ifdef GATE_SEQ_LOG_EN
    ,
    .observed  (obs1)
`endif
  );

  // View of whichever instance is selected
  assign m_a    = sel ? a1    : a0;
  assign m_b    = sel ? b1    : b0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_pass = sel ? pass1 : pass0;
  assign m_err  = sel ? err1  : err0;
`ifdef GATE_SEQ_LOG_EN
  assign m_obs  = sel ? obs1  : obs0;
`endif

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " busy"}, m_busy, 1'b0);
    check({tag, " done"}, m_done, 1'b0);
    check({tag, " pass"}, m_pass, 1'b0);
    check({tag, " err"},  m_err,  3'd0);
    check({tag, " ab"},   {m_a, m_b}, 2'd0);
`ifdef GATE_SEQ_LOG_EN
    check({tag, " obs"},  m_obs,  4'd0);
`endif
  endtask

  // ---------------- driver + model ----------------
  // One sweep on the selected instance. Caller is one #1 past an edge with
  // the DUT idle; the next edge accepts start. Returns one #1 past the edge
  // following DONE (an IDLE cycle), with start left at 'hold'.
  task automatic run_sweep(input logic [3:0] gate_tt, input bit hold, input bit repulse,
                           input bit junk, input int rst_at);
    int         s;
    int         last;
    int         err_c;
    int         err_total;
    logic [3:0] expv;
`ifdef GATE_SEQ_LOG_EN
    logic [3:0] obs_c;
`endif
    s         = sel ? S1 : S0;
    expv      = sel ? EXP1 : EXP0;
    last      = 4 * (s + 1) + 1;
    err_total = 0;
    for (int v = 0; v < 4; v++) if (gate_tt[v] != expv[v]) err_total++;
    tt    = gate_tt;
    start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    for (int c = 1; c <= last; c++) begin
      err_c = 0;
`ifdef GATE_SEQ_LOG_EN
      obs_c = 4'd0;
`endif
      for (int v = 0; v < 4; v++) begin
        if ((v + 1) * (s + 1) < c) begin
          if (gate_tt[v] != expv[v]) err_c++;
`ifdef GATE_SEQ_LOG_EN
          obs_c[v] = gate_tt[v];
`endif
        end
      end
      if (c <= 4 * (s + 1)) begin
        check($sformatf("c%0d busy", c), m_busy, 1'b1);
        check($sformatf("c%0d done", c), m_done, 1'b0);
        check($sformatf("c%0d vec", c), {m_a, m_b}, (c - 1) / (s + 1));
        check($sformatf("c%0d pass", c), m_pass, 1'b0);
      end else begin
        check("done busy", m_busy, 1'b0);
        check("done pulse", m_done, 1'b1);
        check("done vec", {m_a, m_b}, 2'd0);
        check("done pass", m_pass, (err_total == 0));
      end
      check($sformatf("c%0d err", c), m_err, err_c);
`ifdef GATE_SEQ_LOG_EN
      check($sformatf("c%0d obs", c), m_obs, obs_c);
`endif
      if (c == rst_at) begin
        // start raised together with rst: reset must win
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        check_reset_values($sformatf("rst@c%0d", c));
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          check("post-rst done", m_done, 1'b0);
          check("post-rst busy", m_busy, 1'b0);
        end
        return;
      end
      if (c == last) start = hold;
      else start = hold | (repulse && (c == 3 || c == 10)) |
                   (junk && ($urandom_range(0, 3) == 0));
      @(posedge clk); #1;
    end
    check("idle busy", m_busy, 1'b0);
    check("idle done", m_done, 1'b0);
    check("idle vec", {m_a, m_b}, 2'd0);
    check("idle pass held", m_pass, (err_total == 0));
    check("idle err held", m_err, err_total);
`ifdef GATE_SEQ_LOG_EN
    check("idle obs held", m_obs, gate_tt);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    bit hold;
    int rst_at;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    tt    = OR_TT;
    repeat (3) @(posedge clk);
    #1;
    sel = 1'b0; check_reset_values("reset dut0");
    sel = 1'b1; check_reset_values("reset dut1");
    rst = 1'b0;
    sel = 1'b0;
    @(posedge clk); #1;

    // OR gate attached, default timing: done in cycle 21, pass
    run_sweep(OR_TT, 1'b0, 1'b0, 1'b0, 0);
    // AND gate against OR expectation: two mismatches
    run_sweep(AND_TT, 1'b0, 1'b0, 1'b0, 0);
    // start re-pulsed mid-sweep is ignored
    run_sweep(OR_TT, 1'b0, 1'b1, 1'b0, 0);
    // reset mid-sweep at cycle 12, then a fresh passing sweep
    run_sweep(AND_TT, 1'b0, 1'b0, 1'b0, 12);
    run_sweep(OR_TT, 1'b0, 1'b0, 1'b0, 0);
    // start held high: back-to-back sweeps, results cleared at each relaunch
    run_sweep(OR_TT,  1'b1, 1'b0, 1'b0, 0);
    run_sweep(XOR_TT, 1'b1, 1'b0, 1'b0, 0);
    run_sweep(OR_TT,  1'b0, 1'b0, 1'b0, 0);

    // SETTLE=1 instance with gate_c stuck at 1: one mismatch, done in cycle 9
    sel = 1'b1;
    run_sweep(4'b1111, 1'b0, 1'b0, 1'b0, 0);
    run_sweep(NAND_TT, 1'b0, 1'b0, 1'b0, 0);

    // Randomised sweeps on both instances
    for (int i = 0; i < 30; i++) begin
      sel    = 1'($urandom_range(0, 1));
      s      = sel ? S1 : S0;
      rst_at = 0;
      hold   = 1'b0;
      if ($urandom_range(0, 4) == 0) rst_at = $urandom_range(1, 4 * (s + 1));
      else if ($urandom_range(0, 3) == 0) hold = 1'b1;
      run_sweep(4'($urandom_range(0, 15)), hold, 1'b0, 1'b1, rst_at);
    end
    start = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Self-test sequencer for a 2-input combinational gate in the lab datapath (e.g. `or_gate`, `and_gate`). On `start` it drives all four input vectors {a,b} = 00, 01, 10, 11 onto the gate under test and holds each for a programmable settle time. After each settle time it samples the gate output and compares it against a parameterised expected truth table. When the sweep finishes it reports a mismatch count and a pass flag, so the gate check runs in hardware instead of a hand-written stimulus bench.

## Interface
Parameters:
- `EXPECT`, default 4'b1110, expected truth table; bit index = {a,b} (default is OR).
- `SETTLE`, default 4, cycles each vector is driven before sampling; legal range 1..255.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `gate_a`  out  1  drives gate input a.
- `gate_b`  out  1  drives gate input b.
- `gate_c`  in  1  gate output; same clock domain, no synchroniser.
- `busy`  out  1  high from the cycle after an accepted start through the last SAMPLE cycle.
- `done`  out  1  one-cycle pulse at sweep end.
- `pass`  out  1  high when the last completed sweep had zero mismatches.
- `err_count`  out  3  mismatches in the current or last sweep, 0..4.
- `observed`  out  4  captured truth table; present only with `GATE_SEQ_LOG_EN`.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: if `start`=1, go to DRIVE; set vec=0; clear `err_count`, `pass` and `observed`. Otherwise stay.
- DRIVE: `{gate_a,gate_b}` = vec. The settle counter loads SETTLE-1 on entry and decrements each cycle. At 0, go to SAMPLE.
- SAMPLE: inputs are held. At the clock edge, compare `gate_c` with EXPECT[vec]; on mismatch, `err_count` += 1.
  - If vec==3, go to DONE.
  - Otherwise vec += 1 and go to DRIVE.
- DONE: `done`=1 for this single cycle. `pass` is registered as (final `err_count`==0), including a SAMPLE-cycle mismatch on vec 3. Go to IDLE.
- `start` while not in IDLE is ignored; there is no queueing.
- `err_count` saturates at 4; by construction it can never exceed 4.
- vec is 2 bits; the sweep ends at vec 3, with no wrap-around.
- In IDLE and DONE, `gate_a`/`gate_b` hold 0.

## Timing
- Reset values: state=IDLE, vec=0, counter=0, `gate_a`=`gate_b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `observed`=0.
- `rst` mid-sweep aborts on the next edge to the reset values. No `done` pulse is produced.
- `rst` has priority over `start` in the same cycle.
- Each vector occupies SETTLE+1 cycles (SETTLE in DRIVE, 1 in SAMPLE).
- With `start` sampled at edge 0, `done` is high in cycle 4·(SETTLE+1)+1. For the default SETTLE=4 that is cycle 21.
- `start` held high across DONE→IDLE launches a new sweep at the first IDLE edge. `pass`/`err_count` from the previous sweep are cleared at that point.
- Outputs are registered. `gate_c` must settle within SETTLE cycles of a vector change.

## Configuration
- `GATE_SEQ_LOG_EN` defined: adds the `observed[3:0]` port. `observed[vec]` is written with `gate_c` in each SAMPLE cycle, held after DONE, and cleared on reset and on accepted `start`.
- Not defined: the `observed` port and its register do not exist. Pass/fail behaviour is identical.

## Structure
- Package `gate_seq_pkg`:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - truth-table constants OR_TT=4'b1110, AND_TT=4'b1000, XOR_TT=4'b0110, NAND_TT=4'b0111;
  - `SETTLE_W`=8.
- Sub-module `settle_timer`: loadable down-counter. Inputs: `clk`, `rst`, `load`, `load_val`. Output: `zero`. Instantiated once.
- The top level holds the FSM, vec, the comparator and the result registers.

## Test plan
- `or_gate` attached, EXPECT=OR_TT, SETTLE=4, pulse `start` → `done` in cycle 21, `err_count`=0, `pass`=1, `observed`=4'b1110 (with macro).
- Gate replaced by AND, EXPECT=OR_TT → `err_count`=2, `pass`=0, `observed`=4'b1000.
- `gate_c` tied to 1, EXPECT=OR_TT, SETTLE=1 → `done` in cycle 9, `err_count`=1 (vec 00), `pass`=0.
- `start` re-pulsed at cycles 3 and 10 of a sweep → ignored; single `done` at cycle 21.
- `rst` at cycle 12, then `start` → outputs at reset values, no `done`; fresh sweep completes in 21 cycles with `pass`=1.
- `start` held high continuously → back-to-back sweeps, `done` every 22 cycles, `pass` cleared at each relaunch.
